// File: rtl/spike_pulse_shaper.sv
// spike_pulse_shaper
//   Turns rising edges on each FiredIn channel into a fixed-width output pulse
//   of PW_CYC cycles. Each pulse is followed by a refractory period of
//   REFR_CYC cycles. Edges that arrive while a channel is busy are counted as
//   drops.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   FiredIn   per-channel firing levels from the SPI spike driver
//   ClrCnt    synchronous clear of DropCnt / EvtCnt
//   PulseOut  shaped pulses, one bit per channel (registered)
//   Active    OR of PulseOut (registered, aligned with PulseOut)
//   DropCnt   saturating count of dropped edges
//   EvtCnt    saturating count of accepted edges
//
// Build option
//   SPIKE_PULSE_EVTCNT_EN  enables the accepted-edge counter. When it is not
//                          defined, EvtCnt is tied to zero.
//
// Per-channel FSM
//   state | meaning
//   IDLE  | armed, waiting for a rising edge
//   PULSE | driving PulseOut high, cnt counts down the pulse width
//   REFR  | refractory, cnt counts down, edges are dropped

module spike_pulse_shaper #(
    parameter int SZPFIRED = 32,
    parameter int PW_CYC   = 50,
    parameter int REFR_CYC = 100,
    parameter int CNTW     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SZPFIRED-1:0] FiredIn,
    input  logic                ClrCnt,
    output logic [SZPFIRED-1:0] PulseOut,
    output logic                Active,
    output logic [15:0]         DropCnt,
    output logic [15:0]         EvtCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        REFR  = 2'd2
    } state_t;

    localparam int PCW = $clog2(SZPFIRED + 1);
    localparam logic [CNTW-1:0] PW_LOAD   = CNTW'(PW_CYC - 1);
    localparam logic [CNTW-1:0] REFR_LOAD = (REFR_CYC > 0) ? CNTW'(REFR_CYC - 1) : '0;

    state_t [SZPFIRED-1:0]           state, state_nxt;
    logic   [SZPFIRED-1:0][CNTW-1:0] cnt, cnt_nxt;
    logic   [SZPFIRED-1:0]           prev, edge_det, drop, pulse_nxt;

    function automatic logic [PCW-1:0] popcount(input logic [SZPFIRED-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < SZPFIRED; i++) begin
            n = n + PCW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [PCW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

`ifdef SPIKE_PULSE_EVTCNT_EN
    logic [SZPFIRED-1:0] accept;
`endif

    always_comb begin
        edge_det  = FiredIn & ~prev;
        state_nxt = state;
        cnt_nxt   = cnt;
        drop      = '0;
        pulse_nxt = '0;
`ifdef SPIKE_PULSE_EVTCNT_EN
        accept    = '0;
`endif
        for (int i = 0; i < SZPFIRED; i++) begin
            case (state[i])
                IDLE: begin
                    if (edge_det[i]) begin
                        state_nxt[i] = PULSE;
                        cnt_nxt[i]   = PW_LOAD;
`ifdef SPIKE_PULSE_EVTCNT_EN
                        accept[i]    = 1'b1;
`endif
                    end
                end
                PULSE: begin
                    drop[i] = edge_det[i];
                    if (cnt[i] == '0) begin
                        if (REFR_CYC == 0) begin
                            state_nxt[i] = IDLE;
                            cnt_nxt[i]   = '0;
                        end else begin
                            state_nxt[i] = REFR;
                            cnt_nxt[i]   = REFR_LOAD;
                        end
                    end else begin
                        cnt_nxt[i] = cnt[i] - 1'b1;
                    end
                end
                REFR: begin
                    // an edge on the final refractory cycle is still a drop
                    drop[i] = edge_det[i];
                    if (cnt[i] == '0) begin
                        state_nxt[i] = IDLE;
                    end else begin
                        cnt_nxt[i] = cnt[i] - 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
            pulse_nxt[i] = (state_nxt[i] == PULSE);
        end
    end

    always_ff @(posedge clk) begin
        // prev tracks FiredIn through reset so lines already high at release do not fire
        prev <= FiredIn;
        if (reset) begin
            for (int i = 0; i < SZPFIRED; i++) begin
                state[i] <= IDLE;
            end
            cnt      <= '0;
            PulseOut <= '0;
            Active   <= 1'b0;
            DropCnt  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            PulseOut <= pulse_nxt;
            Active   <= |pulse_nxt;
            DropCnt  <= ClrCnt ? 16'h0000 : sat_add(DropCnt, popcount(drop));
        end
    end

`ifdef SPIKE_PULSE_EVTCNT_EN
    always_ff @(posedge clk) begin
        if (reset || ClrCnt) begin
            EvtCnt <= '0;
        end else begin
            EvtCnt <= sat_add(EvtCnt, popcount(accept));
        end
    end
`else
    assign EvtCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_spike_pulse_shaper.sv
// tb_spike_pulse_shaper
//   Directed scenarios plus random traffic on spike_pulse_shaper (PW_CYC=4,
//   REFR_CYC=6, 32 channels). The expected outputs come from a timestamp model.
//   A channel is busy for PW+REFR cycles after its last accepted edge, and its
//   pulse is high for the first PW of them.

module tb_spike_pulse_shaper;

    localparam int N    = 32;
    localparam int PW   = 4;
    localparam int REFR = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  FiredIn;
    logic          ClrCnt;
    logic [N-1:0]  PulseOut;
    logic          Active;
    logic [15:0]   DropCnt;
    logic [15:0]   EvtCnt;

    spike_pulse_shaper #(
        .SZPFIRED(N),
        .PW_CYC  (PW),
        .REFR_CYC(REFR),
        .CNTW    (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .FiredIn (FiredIn),
        .ClrCnt  (ClrCnt),
        .PulseOut(PulseOut),
        .Active  (Active),
        .DropCnt (DropCnt),
        .EvtCnt  (EvtCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int           t = 0;
    int           la [N];
    bit           lav [N];
    logic [N-1:0] mprev = '0;
    int           mdrop = 0;
    int           mevt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step(input logic [N-1:0] fin, input logic clr, input logic rst);
        int           nd;
        int           na;
        logic [N-1:0] exp_pulse;
        FiredIn = fin;
        ClrCnt  = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        t++;
        nd = 0;
        na = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) lav[i] = 1'b0;
            mdrop = 0;
            mevt  = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fin[i] && !mprev[i]) begin
                    if (lav[i] && (t - la[i]) <= PW + REFR) begin
                        nd++;
                    end else begin
                        la[i]  = t;
                        lav[i] = 1'b1;
                        na++;
                    end
                end
            end
            mdrop = clr ? 0 : ((mdrop + nd > 65535) ? 65535 : mdrop + nd);
            mevt  = clr ? 0 : ((mevt + na > 65535) ? 65535 : mevt + na);
        end
        mprev = fin;
        for (int i = 0; i < N; i++) exp_pulse[i] = lav[i] && ((t - la[i]) < PW);
        chk("pulse", PulseOut, exp_pulse);
        chk("active", {31'b0, Active}, {31'b0, |exp_pulse});
        chk("dropcnt", {16'b0, DropCnt}, mdrop);
`ifdef SPIKE_PULSE_EVTCNT_EN
        chk("evtcnt", {16'b0, EvtCnt}, mevt);
`else
        chk("evtcnt", {16'b0, EvtCnt}, 32'h0);
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
    endtask

    initial begin
        int           hi;
        int           iter;
        logic [N-1:0] fin;

        for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b1);
        idle(9);

        // single spike on ch 3, held high
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            step(32'h8, 1'b0, 1'b0);
            if (PulseOut[3]) hi++;
        end
        chk("single_width", hi, PW);
        chk("single_drop", {16'b0, DropCnt}, 0);
`ifdef SPIKE_PULSE_EVTCNT_EN
        chk("single_evt", {16'b0, EvtCnt}, 1);
`endif
        idle(12);

        // refractory: rises at s=0,3,10 (last is final REFR cycle), then s=12
        hi = 0;
        for (int s = 0; s < 12; s++) begin
            step((s == 0 || s == 3 || s == 10) ? 32'h1 : 32'h0, 1'b0, 1'b0);
            if (PulseOut[0]) hi++;
        end
        chk("refr_width", hi, PW);
        chk("refr_drop", {16'b0, DropCnt}, 2);
        step(32'h1, 1'b0, 1'b0);
        chk("refr_rearm", {31'b0, PulseOut[0]}, 1);
        idle(12);

        // simultaneous edges on all channels
        step('0, 1'b1, 1'b0);
        step('1, 1'b0, 1'b0);
        chk("simul_pulse", PulseOut, 32'hFFFF_FFFF);
`ifdef SPIKE_PULSE_EVTCNT_EN
        chk("simul_evt", {16'b0, EvtCnt}, 32);
`endif
        step('0, 1'b0, 1'b0);
        step('1, 1'b0, 1'b0);
        chk("simul_drop", {16'b0, DropCnt}, 32);

        // saturation preload, coarse then single-step
        iter = 0;
        while (mdrop < 65534 - 64 && iter < 20000) begin
            step('1, 1'b0, 1'b0);
            step('0, 1'b0, 1'b0);
            iter++;
        end
        iter = 0;
        while (mdrop < 65534 && iter < 2000) begin
            step(32'h1, 1'b0, 1'b0);
            step(32'h0, 1'b0, 1'b0);
            iter++;
        end
        chk("preload", {16'b0, DropCnt}, 32'hFFFE);
        idle(12);
        step(32'hE, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
        step(32'hE, 1'b0, 1'b0);
        chk("saturate", {16'b0, DropCnt}, 32'hFFFF);
        step(32'h0, 1'b0, 1'b0);
        step(32'hE, 1'b1, 1'b0);
        chk("clr_wins", {16'b0, DropCnt}, 0);
        idle(12);

        // reset mid-pulse with ch 5 held high
        step(32'h20, 1'b0, 1'b0);
        step(32'h20, 1'b0, 1'b0);
        chk("rst_pre", {31'b0, PulseOut[5]}, 1);
        step(32'h20, 1'b0, 1'b1);
        chk("rst_abort", PulseOut, 0);
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            step(32'h20, 1'b0, 1'b0);
            if (PulseOut[5]) hi++;
        end
        chk("rst_noretrig", hi, 0);
        step(32'h0, 1'b0, 1'b0);
        step(32'h20, 1'b0, 1'b0);
        chk("rst_rearm", {31'b0, PulseOut[5]}, 1);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            fin = mprev ^ ($urandom & $urandom & $urandom);
            step(fin, ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
